// File: rtl/pipe_pkg.sv
// Shared types for the pipeline controller: FSM states and per-stage stall encodings.
package pipe_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } pipe_state_e;

    // Bit order is pc, if_id, id_ex, ex_mem, mem_wb, wb (bit 0 = pc).
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    function automatic logic [5:0] stall_encode(input logic mem, input logic ex, input logic id);
        if (mem)     return STALL_MEM;
        else if (ex) return STALL_EX;
        else if (id) return STALL_ID;
        else         return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Up-counter with synchronous clear; saturates at MAX_VAL or wraps, chosen per instance.
module sat_counter #(
    parameter int               WIDTH    = 8,
    parameter bit               SATURATE = 1'b1,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            if (SATURATE && (count_q >= MAX_VAL)) count_d = MAX_VAL;
            else                                  count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritised stalls, one-cycle exception flush redirect,
// and stall/flush statistics with a sticky stall-timeout flag.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int STALL_LIMIT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic        stall_timeout
);

    localparam int RW = $clog2(STALL_LIMIT + 1);
    localparam logic [RW-1:0] LIMIT     = RW'(STALL_LIMIT);
    localparam logic [RW-1:0] LIMIT_M1  = RW'(STALL_LIMIT - 1);

    pipe_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        timeout_q, timeout_d;
    logic [RW-1:0] run_len;

    // Reset gates the visible outputs so a flush in progress is dropped immediately.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stall   = STALL_NONE;
        flush   = 1'b0;
        new_pc  = 32'h0;
        unique case (state_q)
            RUN: begin
                stall = stall_encode(stallreq_mem, stallreq_ex, stallreq_id);
                if (flush_req) begin
                    state_d = FLUSH;
                    pc_d    = flush_pc;
                end
            end
            FLUSH: begin
                flush   = 1'b1;
                new_pc  = pc_q;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (rst) begin
            stall  = STALL_NONE;
            flush  = 1'b0;
            new_pc = 32'h0;
        end
    end

    // Timeout sets on the same edge that carries the run length up to the limit.
    always_comb begin
        timeout_d = timeout_q;
        if (stall[0] && (run_len >= LIMIT_M1)) timeout_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= 32'h0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

    sat_counter #(.WIDTH(32), .SATURATE(1'b1), .MAX_VAL(32'hFFFF_FFFF)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (1'b0),
        .inc_i   (stall[0]),
        .count_o (stall_cnt)
    );

    sat_counter #(.WIDTH(16), .SATURATE(1'b0), .MAX_VAL(16'hFFFF)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (1'b0),
        .inc_i   (flush),
        .count_o (flush_cnt)
    );

    sat_counter #(.WIDTH(RW), .SATURATE(1'b1), .MAX_VAL(LIMIT)) u_run_len (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (~stall[0]),
        .inc_i   (stall[0]),
        .count_o (run_len)
    );

endmodule
